// File: rtl/hept_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hept_pkg
//  Description : Shared types and constants for the heptagon-area pipeline
//                flow controller: frame geometry, memory widths and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hept_pkg;

  // Frame geometry: five heptagons of seven points each.
  localparam int NUM_POLY     = 5;
  localparam int PTS_PER_POLY = 7;
  localparam int NUM_PTS      = NUM_POLY * PTS_PER_POLY;

  // Point-memory address width and coordinate width.
  localparam int ADDR_W  = 6;
  localparam int COORD_W = 10;

  // Beat counters: point index within a heptagon and heptagon index.
  localparam int PT_W   = 3;
  localparam int POLY_W = 3;
  localparam logic [PT_W-1:0]   PT_LAST   = PT_W'(PTS_PER_POLY - 1);
  localparam logic [POLY_W-1:0] POLY_LAST = POLY_W'(NUM_POLY - 1);

  // Sequencer states with a fixed 3-bit encoding.
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_LOAD = 3'd0,
    ST_CLR  = 3'd1,
    ST_SORT = 3'd2,
    ST_AREA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage : hept_pkg
`default_nettype wire

// File: rtl/hept_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : hept_watchdog
//  Description : Saturating stall counter shared by the SORT and AREA stages.
//                expired is high while the count sits at TIMEOUT-1, i.e. on
//                the TIMEOUT-th enabled cycle after a clear. Never wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module hept_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles since the last clear, holding at the terminal value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en && (r_count != C_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == C_LAST);

endmodule : hept_watchdog
`default_nettype wire

// File: rtl/hept_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hept_flow_ctrl
//  Description : Frame sequencer for the heptagon-area pipeline. Loads 35
//                points into the shared point memory, pulses the sorter
//                clear, runs the sorter and the area stage through their
//                handshakes and flags completion. A shared watchdog moves
//                the sequencer to a sticky error state on a stalled stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module hept_flow_ctrl
  import hept_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COORD_W-1:0] mem_wx,
  output logic [COORD_W-1:0] mem_wy,
  output logic               sort_clr,
  output logic               point_on,
  input  logic               cal_on,
  output logic               area_on,
  input  logic               area_done,
  output logic               done,
  output logic               busy,
  output logic               err
);

  state_t r_state;
  state_t w_next_state;

  // Beat counters; r_addr tracks poly*7+pt by incrementing alongside them.
  logic [PT_W-1:0]   r_pt;
  logic [POLY_W-1:0] r_poly;
  logic [ADDR_W-1:0] r_addr;

  // Registered outputs.
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [COORD_W-1:0] r_mem_wx;
  logic [COORD_W-1:0] r_mem_wy;
  logic               r_sort_clr;
  logic               r_point_on;
  logic               r_area_on;
  logic               r_done;
  logic               r_busy;
  logic               r_err;

  // Next-cycle output values decoded from the next state.
  logic w_mem_we;
  logic w_sort_clr;
  logic w_point_on;
  logic w_area_on;
  logic w_done;
  logic w_busy;
  logic w_err;

  logic w_accept;
  logic w_last_beat;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;

  // Handshake inputs only matter in their own state; in_ready gates in_valid.
  assign in_ready    = (r_state == ST_LOAD);
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = w_accept && (r_poly == POLY_LAST) && (r_pt == PT_LAST);

  // The watchdog restarts on entry to SORT (via CLR) and on entry to AREA,
  // and stays cleared while loading. In ERR it simply holds.
  assign w_wd_en  = (r_state == ST_SORT) || (r_state == ST_AREA);
  assign w_wd_clr = (r_state == ST_LOAD) || (r_state == ST_CLR) ||
                    ((r_state == ST_SORT) && cal_on);

  hept_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_wd_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a stage handshake takes priority over watchdog expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_last_beat) begin
          w_next_state = ST_CLR;
        end
      end
      ST_CLR: begin
        w_next_state = ST_SORT;
      end
      ST_SORT: begin
        if (cal_on) begin
          w_next_state = ST_AREA;
        end else if (w_wd_expired) begin
          w_next_state = ST_ERR;
        end
      end
      ST_AREA: begin
        if (area_done) begin
          w_next_state = ST_DONE;
        end else if (w_wd_expired) begin
          w_next_state = ST_ERR;
        end
      end
      ST_DONE: begin
        w_next_state = ST_LOAD;
      end
      ST_ERR: begin
        w_next_state = ST_ERR;
      end
      default: begin
        w_next_state = ST_LOAD;
      end
    endcase
  end

  // Output decode of the next state, so the registered outputs track the
  // state they belong to without an extra cycle of lag.
  always_comb begin
    w_mem_we   = w_accept;
    w_sort_clr = (w_next_state == ST_CLR);
    w_point_on = (w_next_state == ST_SORT);
    w_area_on  = (w_next_state == ST_AREA);
    w_done     = (w_next_state == ST_DONE);
    w_busy     = (w_next_state != ST_LOAD);
    w_err      = (w_next_state == ST_ERR);
  end

  // Output registers; write address and data only move on an accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wx   <= '0;
      r_mem_wy   <= '0;
      r_sort_clr <= 1'b0;
      r_point_on <= 1'b0;
      r_area_on  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_we   <= w_mem_we;
      r_sort_clr <= w_sort_clr;
      r_point_on <= w_point_on;
      r_area_on  <= w_area_on;
      r_done     <= w_done;
      r_busy     <= w_busy;
      r_err      <= w_err;
      if (w_accept) begin
        r_mem_addr <= r_addr;
        r_mem_wx   <= in_x;
        r_mem_wy   <= in_y;
      end
    end
  end

  // Beat counters: pt wraps 6->0 with poly++, and the whole frame position
  // rewinds after the 35th beat so the next frame starts at address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pt   <= '0;
      r_poly <= '0;
      r_addr <= '0;
    end else if (w_last_beat || (r_state == ST_DONE)) begin
      r_pt   <= '0;
      r_poly <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= r_addr + 1'b1;
      if (r_pt == PT_LAST) begin
        r_pt   <= '0;
        r_poly <= r_poly + 1'b1;
      end else begin
        r_pt <= r_pt + 1'b1;
      end
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wx   = r_mem_wx;
  assign mem_wy   = r_mem_wy;
  assign sort_clr = r_sort_clr;
  assign point_on = r_point_on;
  assign area_on  = r_area_on;
  assign done     = r_done;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule : hept_flow_ctrl
`default_nettype wire
